dco_tuner: RTL and testbench

Downstream stage of the PLL loop filter: consumes the filter's unsigned `lf_out` word and drives the DCO tuning code. It splits `lf_out` into an integer tuning code and a fractional part, clamps and slew-limits the integer code, and dithers the fraction with a first-order sigma-delta modulator. It also reports slewing and lock status.

---
 rtl/dco_tuner.sv | 130 +++++++++++++
 tb/tb_dco_tuner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dco_tuner.sv
// PLL loop-filter back end: clamps and slew-limits the integer tuning code,
// dithers the fractional part with a first-order sigma-delta, reports slew/lock.
module dco_tuner #(
    parameter int LF_OUT_SIZE = 16,
    parameter int FRAC_SIZE   = 8,
    parameter logic [LF_OUT_SIZE-FRAC_SIZE-1:0] CODE_MIN   = 8'h10,
    parameter logic [LF_OUT_SIZE-FRAC_SIZE-1:0] CODE_MAX   = 8'hF0,
    parameter logic [LF_OUT_SIZE-FRAC_SIZE-1:0] RESET_CODE = 8'h80,
    parameter int MAX_STEP    = 4,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                              clk_ref_i,
    input  logic                              rst_i,
    input  logic                              lf_valid_i,
    input  logic [LF_OUT_SIZE-1:0]            lf_out_i,
    output logic [LF_OUT_SIZE-FRAC_SIZE-1:0]  dco_code_o,
    output logic                              slewing_o,
    output logic                              locked_o
);

    localparam int INT_SIZE = LF_OUT_SIZE - FRAC_SIZE;
    localparam int CNT_W    = $clog2(LOCK_COUNT + 1);

    typedef logic [INT_SIZE:0] wide_t;

    localparam wide_t             STEP_W  = wide_t'(MAX_STEP);
    localparam wide_t             TOL_W   = wide_t'(LOCK_TOL);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_COUNT);

    logic [INT_SIZE-1:0]  target_q, target_d;
    logic [INT_SIZE-1:0]  cur_q, cur_d;
    logic [INT_SIZE-1:0]  code_q, code_d;
    logic [FRAC_SIZE-1:0] frac_q, frac_d;
    logic [FRAC_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 slew_q, slew_d;
    logic                 lock_q, lock_d;

    logic [INT_SIZE-1:0]  lf_int;
    logic [INT_SIZE-1:0]  clamped;
    wide_t                up_diff, dn_diff, step, cur_w, new_diff;
    logic [FRAC_SIZE:0]   sd_sum;
    logic                 carry;

    always_comb begin
        target_d = target_q;
        frac_d   = frac_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        cur_d    = cur_q;
        step     = '0;
        cur_w    = '0;
        new_diff = '0;

        lf_int = lf_out_i[LF_OUT_SIZE-1:FRAC_SIZE];
        if (lf_int < CODE_MIN)
            clamped = CODE_MIN;
        else if (lf_int > CODE_MAX)
            clamped = CODE_MAX;
        else
            clamped = lf_int;

        // Differences carry an extra bit so neither direction can wrap.
        up_diff = {1'b0, target_q} - {1'b0, cur_q};
        dn_diff = {1'b0, cur_q} - {1'b0, target_q};
        if (cur_q < target_q) begin
            step  = (up_diff > STEP_W) ? STEP_W : up_diff;
            cur_w = {1'b0, cur_q} + step;
            cur_d = cur_w[INT_SIZE-1:0];
        end else if (cur_q > target_q) begin
            step  = (dn_diff > STEP_W) ? STEP_W : dn_diff;
            cur_w = {1'b0, cur_q} - step;
            cur_d = cur_w[INT_SIZE-1:0];
        end

        sd_sum = {1'b0, acc_q} + {1'b0, frac_q};
        carry  = sd_sum[FRAC_SIZE];
        acc_d  = sd_sum[FRAC_SIZE-1:0];

        // The dither bit is dropped at the top code so the output never exceeds CODE_MAX.
        if (cur_q == CODE_MAX)
            code_d = cur_q;
        else
            code_d = cur_q + {{(INT_SIZE-1){1'b0}}, carry};

        slew_d = (cur_q != target_q);

        if (lf_valid_i) begin
            target_d = clamped;
            frac_d   = lf_out_i[FRAC_SIZE-1:0];
            if (clamped > target_q)
                new_diff = {1'b0, clamped} - {1'b0, target_q};
            else
                new_diff = {1'b0, target_q} - {1'b0, clamped};
            if (new_diff <= TOL_W)
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            else
                cnt_d = '0;
            lock_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            target_q <= RESET_CODE;
            cur_q    <= RESET_CODE;
            code_q   <= RESET_CODE;
            frac_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            slew_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            code_q   <= code_d;
            frac_q   <= frac_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            slew_q   <= slew_d;
            lock_q   <= lock_d;
        end
    end

    assign dco_code_o = code_q;
    assign slewing_o  = slew_q;
    assign locked_o   = lock_q;

endmodule

// File: tb/tb_dco_tuner.sv
// Directed plus randomized bench for dco_tuner; every cycle is also checked
// against an arithmetic reference model of the tuner's behaviour.
module tb_dco_tuner;

    logic        clk_ref;
    logic        rst;
    logic        lf_valid;
    logic [15:0] lf_out;
    logic [7:0]  dco_code;
    logic        slewing;
    logic        locked;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_target, m_cur, m_frac, m_acc, m_cnt, m_code, m_slew, m_lock;

    dco_tuner dut (
        .clk_ref_i  (clk_ref),
        .rst_i      (rst),
        .lf_valid_i (lf_valid),
        .lf_out_i   (lf_out),
        .dco_code_o (dco_code),
        .slewing_o  (slewing),
        .locked_o   (locked)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit v, input int lf);
        int n_cur, n_code, n_slew, sum, carry, ni, d;
        if (r) begin
            m_target = 'h80; m_cur = 'h80; m_frac = 0; m_acc = 0;
            m_cnt = 0; m_code = 'h80; m_slew = 0; m_lock = 0;
            return;
        end
        sum   = m_acc + m_frac;
        carry = (sum >= 256) ? 1 : 0;
        if (m_cur < m_target)
            n_cur = m_cur + imin(4, m_target - m_cur);
        else if (m_cur > m_target)
            n_cur = m_cur - imin(4, m_cur - m_target);
        else
            n_cur = m_cur;
        n_code = (m_cur == 'hF0) ? m_cur : m_cur + carry;
        n_slew = (m_cur != m_target) ? 1 : 0;
        if (v) begin
            ni = lf / 256;
            if (ni < 'h10) ni = 'h10;
            if (ni > 'hF0) ni = 'hF0;
            d = (ni > m_target) ? ni - m_target : m_target - ni;
            m_cnt    = (d <= 2) ? imin(m_cnt + 1, 8) : 0;
            m_lock   = (m_cnt == 8) ? 1 : 0;
            m_target = ni;
            m_frac   = lf % 256;
        end
        m_acc  = sum % 256;
        m_cur  = n_cur;
        m_code = n_code;
        m_slew = n_slew;
    endtask

    task automatic tick(input bit r, input bit v, input logic [15:0] lf);
        rst      = r;
        lf_valid = v;
        lf_out   = lf;
        @(posedge clk_ref);
        #1;
        model_step(r, v, int'(lf));
        check("model_code", 32'(dco_code), 32'(m_code));
        check("model_slew", 32'(slewing), 32'(m_slew));
        check("model_lock", 32'(locked), 32'(m_lock));
    endtask

    initial begin
        logic [7:0] exp_code [6];
        logic       exp_slew [6];
        int         cnt81, cnt80, last81;
        int         t;
        logic [15:0] lf;
        bit          r, v;

        rst = 1'b1; lf_valid = 1'b0; lf_out = '0;

        // Reset and idle hold
        tick(1, 0, 16'h0);
        tick(1, 0, 16'h0);
        check("rst_code", 32'(dco_code), 32'h80);
        check("rst_slew", 32'(slewing), 0);
        check("rst_lock", 32'(locked), 0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 16'hFFFF);
            check("idle_code", 32'(dco_code), 32'h80);
        end

        // Slew up to 0x90
        exp_code = '{8'h80, 8'h80, 8'h84, 8'h88, 8'h8C, 8'h90};
        exp_slew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            tick(0, (i == 0), 16'h9000);
            check("slew_up_code", 32'(dco_code), 32'(exp_code[i]));
            check("slew_up_flag", 32'(slewing), 32'(exp_slew[i]));
        end

        // Clamp high with saturation, then clamp low
        tick(1, 0, 16'h0);
        tick(0, 1, 16'hFF80);
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 16'h0);
            check("sat_le_max", 32'(dco_code <= 8'hF0), 1);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 16'h0);
            check("sat_settle", 32'(dco_code), 32'hF0);
        end
        tick(0, 1, 16'h0500);
        for (int i = 0; i < 70; i++) tick(0, 0, 16'h0);
        check("clamp_low", 32'(dco_code), 32'h10);

        // Dither 0x40/256 around 0x80
        tick(1, 0, 16'h0);
        tick(0, 1, 16'h8040);
        cnt81 = 0; cnt80 = 0; last81 = -1;
        for (int k = 1; k <= 256; k++) begin
            tick(0, 0, 16'h0);
            if (dco_code == 8'h81) begin
                cnt81++;
                if (last81 >= 0) check("dither_gap", 32'(k - last81), 4);
                last81 = k;
            end else if (dco_code == 8'h80) begin
                cnt80++;
            end
        end
        check("dither_hi", 32'(cnt81), 64);
        check("dither_lo", 32'(cnt80), 192);

        // Lock detect
        tick(1, 0, 16'h0);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 1, (i % 2 == 1) ? 16'h8100 : 16'h8000);
            check("lock_rise", 32'(locked), (i == 8) ? 1 : 0);
            tick(0, 0, 16'h0);
        end
        tick(0, 1, 16'h8500);
        check("lock_fall", 32'(locked), 0);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 1, 16'h8500);
            check("lock_restart", 32'(locked), (i == 8) ? 1 : 0);
        end

        // Reversal mid-slew, then reset mid-slew with concurrent strobe
        tick(1, 0, 16'h0);
        tick(0, 1, 16'hF000);
        tick(0, 0, 16'h0);
        tick(0, 0, 16'h0);
        tick(0, 1, 16'h7000);
        check("rev_pre", 32'(dco_code), 32'h88);
        tick(0, 0, 16'h0);
        check("rev_peak", 32'(dco_code), 32'h8C);
        tick(0, 0, 16'h0);
        check("rev_back", 32'(dco_code), 32'h88);
        tick(0, 1, 16'hF000);
        tick(0, 0, 16'h0);
        tick(0, 0, 16'h0);
        tick(1, 1, 16'hFFFF);
        check("midrst_code", 32'(dco_code), 32'h80);
        check("midrst_slew", 32'(slewing), 0);
        check("midrst_lock", 32'(locked), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                t = m_target + int'($urandom_range(0, 6)) - 3;
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                lf = {t[7:0], 8'($urandom)};
            end else begin
                lf = 16'($urandom);
            end
            tick(r, v, lf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
